// File: rtl/s1_fetch_unit.sv
// Stage-1 fetch unit: owns the fetch PC, issues instruction-memory reads with
// one-cycle latency, and buffers the fetched instruction across hard stalls.
module s1_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_2000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hard_stall,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] redirect_pc,
  input  logic        s1_kill,
  output logic [31:0] imem_addr,
  output logic        imem_re,
  input  logic [31:0] imem_dout,
  output logic [31:0] s1_pc,
  output logic [31:0] s1_inst,
  output logic        s1_valid
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic [1:0] SEL_STALL = 2'd1;
  localparam logic [1:0] SEL_S3    = 2'd2;

  state_e      state_q, state_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] hold_inst_q, hold_inst_d;

  logic [31:0] issue_addr;
  logic        issue_re;

  // Redirect targets are word-aligned; the low bits are deliberately dropped.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_comb begin
    issue_re   = 1'b1;
    issue_addr = req_pc_q + 32'd4;
    if (hard_stall) begin
      issue_re   = 1'b0;
      issue_addr = req_pc_q;
    end else if (state_q == ST_BOOT) begin
      issue_addr = RESET_PC;
    end else if (pc_sel == SEL_S3) begin
      issue_addr = {redirect_pc[31:2], 2'b00};
    end else if (pc_sel == SEL_STALL) begin
      issue_addr = req_pc_q;
    end
  end

  // Reset is synchronous, so gate the outputs directly while it is asserted.
  assign imem_re   = reset_n & issue_re;
  assign imem_addr = reset_n ? issue_addr : RESET_PC;

  always_comb begin
    state_d      = state_q;
    req_pc_d     = req_pc_q;
    resp_valid_d = resp_valid_q;
    hold_inst_d  = hold_inst_q;
    if (issue_re) begin
      req_pc_d     = issue_addr;
      resp_valid_d = 1'b1;
    end
    case (state_q)
      ST_BOOT: if (!hard_stall) state_d = ST_RUN;
      ST_RUN: begin
        if (hard_stall) begin
          state_d     = ST_HOLD;
          hold_inst_d = imem_dout;
        end
      end
      ST_HOLD: if (!hard_stall) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; all next-state
  // math lives in the always_comb above so there is no ordering hazard here.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_BOOT;
      req_pc_q     <= RESET_PC;
      resp_valid_q <= 1'b0;
      hold_inst_q  <= NOP_INST;
    end else begin
      state_q      <= state_d;
      req_pc_q     <= req_pc_d;
      resp_valid_q <= resp_valid_d;
      hold_inst_q  <= hold_inst_d;
    end
  end

  // The release cycle of a stall is still HOLD, so the buffered word is consumed.
  assign s1_valid = reset_n & resp_valid_q & ~s1_kill & (state_q != ST_BOOT);
  assign s1_inst  = !s1_valid            ? NOP_INST    :
                    (state_q == ST_HOLD) ? hold_inst_q : imem_dout;
  assign s1_pc    = reset_n ? req_pc_q : RESET_PC;

endmodule
